// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared limits and helpers for the stream pipe register
// Purpose: legal Depth range and the width of the occupancy counter.
// Ports: none (package).
package stream_pkg;

    localparam int DEPTH_MIN = 1;
    localparam int DEPTH_MAX = 16;

    // Occupancy counts 0..Depth+1 (skid slot included), so size for Depth+2 codes.
    function automatic int usage_width(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/stream_pipe_register_if.sv
// rtl/stream_pipe_register_if.sv - valid/ready/data link between pipe stages
// Purpose: one handshake hop; master drives valid/data, slave drives ready.
// Ports: valid, ready, data (type T).
interface stream_pipe_register_if #(
    parameter type T = logic
);
    logic valid;
    logic ready;
    T     data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/stream_pipe_stage.sv
// rtl/stream_pipe_stage.sv - one valid/data register stage of the pipe
// Purpose: holds one beat; loads when empty or when its beat leaves this cycle.
// Ports: clk_i, rst_i (sync, active-high), clr_i, in_if (slave), out_if (master).
module stream_pipe_stage #(
    parameter type T = logic
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clr_i,
    stream_pipe_register_if.slave   in_if,
    stream_pipe_register_if.master  out_if
);

    logic valid_q, valid_d;
    T     data_q, data_d;
    logic load;

    // Ready ripples back through empty stages, which is what collapses bubbles.
    assign in_if.ready  = ~valid_q | out_if.ready;
    assign load         = in_if.valid & in_if.ready;
    assign out_if.valid = valid_q;
    assign out_if.data  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (out_if.ready) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            data_d  = in_if.data;
        end
        if (clr_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/stream_pipe_register.sv
// rtl/stream_pipe_register.sv - Depth-stage elastic pipe register with optional skid slot
// Purpose: in-order valid/ready pipeline, one beat per cycle, with occupancy count.
// Ports: clk_i, rst_i (sync, active-high), clr_i; upstream valid_i/ready_o/data_i;
//        downstream valid_o/ready_i/data_o; usage_o = beats currently held.
module stream_pipe_register
    import stream_pkg::*;
#(
    parameter type T        = logic,
    parameter int  Depth    = 2,
    parameter bit  CutReady = 1'b0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clr_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    input  T                               data_i,
    output logic                           valid_o,
    input  logic                           ready_i,
    output T                               data_o,
    output logic [usage_width(Depth)-1:0]  usage_o
);

    localparam int UW = usage_width(Depth);

    if ((Depth < DEPTH_MIN) || (Depth > DEPTH_MAX)) begin : g_depth_check
        $error("stream_pipe_register: Depth must be within 1..16");
    end

    // link[0] feeds the first stage, link[Depth] is the output port.
    stream_pipe_register_if #(.T(T)) link [0:Depth] ();

    for (genvar k = 0; k < Depth; k++) begin : g_stage
        stream_pipe_stage #(.T(T)) u_stage (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .clr_i  (clr_i),
            .in_if  (link[k]),
            .out_if (link[k+1])
        );
    end

    // Clear blanks both handshakes so nothing transfers while contents are dropped.
    assign link[Depth].ready = ready_i & ~clr_i;
    assign valid_o           = link[Depth].valid & ~clr_i;
    assign data_o            = link[Depth].data;

    if (CutReady) begin : g_skid
        logic skid_valid_q, skid_valid_d;
        T     skid_data_q, skid_data_d;

        // ready_o comes only from the skid flag, cutting the ready_i path.
        assign ready_o       = ~skid_valid_q & ~clr_i;
        // A held skid beat has priority; ready_o is low then, so valid_i is ignored.
        assign link[0].valid = skid_valid_q | valid_i;
        assign link[0].data  = skid_valid_q ? skid_data_q : data_i;

        always_comb begin
            skid_valid_d = skid_valid_q;
            skid_data_d  = skid_data_q;
            if (clr_i) begin
                skid_valid_d = 1'b0;
            end else if (skid_valid_q) begin
                if (link[0].ready) begin
                    skid_valid_d = 1'b0;
                end
            end else if (valid_i && !link[0].ready) begin
                skid_valid_d = 1'b1;
                skid_data_d  = data_i;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                skid_valid_q <= 1'b0;
                skid_data_q  <= '0;
            end else begin
                skid_valid_q <= skid_valid_d;
                skid_data_q  <= skid_data_d;
            end
        end
    end else begin : g_no_skid
        assign ready_o       = link[0].ready & ~clr_i;
        assign link[0].valid = valid_i;
        assign link[0].data  = data_i;
    end

    logic          in_xfer;
    logic          out_xfer;
    logic [UW-1:0] usage_q, usage_d;

    assign in_xfer  = valid_i & ready_o;
    assign out_xfer = valid_o & ready_i;

    always_comb begin
        usage_d = usage_q + UW'(in_xfer) - UW'(out_xfer);
        if (clr_i) begin
            usage_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            usage_q <= '0;
        end else begin
            usage_q <= usage_d;
        end
    end

    assign usage_o = usage_q;

endmodule

// File: tb/tb_stream_pipe_register.sv
// tb/tb_stream_pipe_register.sv - directed bench for stream_pipe_register (Depth=3, both CutReady)
module tb_stream_pipe_register;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       rdy;
    logic       ready0, ready1;
    logic       valid0, valid1;
    logic [7:0] data0, data1;
    logic [2:0] usage0, usage1;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    stream_pipe_register_if #(.T(logic [7:0])) up_if ();
    assign up_if.ready = ready0;

    stream_pipe_register #(.T(logic [7:0]), .Depth(3), .CutReady(1'b0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr),
        .valid_i(up_if.valid), .ready_o(ready0), .data_i(up_if.data),
        .valid_o(valid0), .ready_i(rdy), .data_o(data0), .usage_o(usage0)
    );

    stream_pipe_register #(.T(logic [7:0]), .Depth(3), .CutReady(1'b1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr),
        .valid_i(up_if.valid), .ready_o(ready1), .data_i(up_if.data),
        .valid_o(valid1), .ready_i(rdy), .data_o(data1), .usage_o(usage1)
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        up_if.valid = 1'b0;
        rdy = 1'b1;
        repeat (6) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; rdy = 1'b0; up_if.valid = 1'b0; up_if.data = 8'h00;
        step(); step();
        rst = 1'b0;
        #1;
        vectors += 8;
        if (valid0 !== 1'b0) begin miscompares++; $display("FAIL reset_valid0 got %b want 0", valid0); end
        if (data0 !== 8'h00) begin miscompares++; $display("FAIL reset_data0 got %h want 00", data0); end
        if (usage0 !== 3'd0) begin miscompares++; $display("FAIL reset_usage0 got %0d want 0", usage0); end
        if (ready0 !== 1'b1) begin miscompares++; $display("FAIL reset_ready0 got %b want 1", ready0); end
        if (valid1 !== 1'b0) begin miscompares++; $display("FAIL reset_valid1 got %b want 0", valid1); end
        if (data1 !== 8'h00) begin miscompares++; $display("FAIL reset_data1 got %h want 00", data1); end
        if (usage1 !== 3'd0) begin miscompares++; $display("FAIL reset_usage1 got %0d want 0", usage1); end
        if (ready1 !== 1'b1) begin miscompares++; $display("FAIL reset_ready1 got %b want 1", ready1); end
    endtask

    task automatic test_latency();
        logic [7:0] din [7]  = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00};
        logic       expv [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] expd [7] = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
        rdy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            up_if.valid = (i < 3);
            up_if.data  = din[i];
            #1;
            vectors += 2;
            if (valid0 !== expv[i]) begin miscompares++; $display("FAIL latency_valid0 cyc %0d got %b want %b", i, valid0, expv[i]); end
            if (valid1 !== expv[i]) begin miscompares++; $display("FAIL latency_valid1 cyc %0d got %b want %b", i, valid1, expv[i]); end
            if (expv[i]) begin
                vectors += 2;
                if (data0 !== expd[i]) begin miscompares++; $display("FAIL latency_data0 cyc %0d got %h want %h", i, data0, expd[i]); end
                if (data1 !== expd[i]) begin miscompares++; $display("FAIL latency_data1 cyc %0d got %h want %h", i, data1, expd[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic       ev0 [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] ed0 [5] = '{8'hA0, 8'hA1, 8'hA2, 8'h00, 8'h00};
        logic [7:0] ed1 [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00};
        logic       ev1 [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            up_if.valid = 1'b1;
            up_if.data  = 8'hA0 + 8'(i);
        end
        step();
        up_if.data = 8'hA3;
        #1;
        vectors += 5;
        if (usage0 !== 3'd3) begin miscompares++; $display("FAIL bp_usage0_full got %0d want 3", usage0); end
        if (ready0 !== 1'b0) begin miscompares++; $display("FAIL bp_ready0_full got %b want 0", ready0); end
        if (usage1 !== 3'd3) begin miscompares++; $display("FAIL bp_usage1_stages got %0d want 3", usage1); end
        if (ready1 !== 1'b1) begin miscompares++; $display("FAIL bp_ready1_skid got %b want 1", ready1); end
        if (data0 !== 8'hA0) begin miscompares++; $display("FAIL bp_hold_data0 got %h want a0", data0); end
        step();
        up_if.valid = 1'b0;
        #1;
        vectors += 5;
        if (usage1 !== 3'd4) begin miscompares++; $display("FAIL bp_usage1_full got %0d want 4", usage1); end
        if (ready1 !== 1'b0) begin miscompares++; $display("FAIL bp_ready1_full got %b want 0", ready1); end
        if (usage0 !== 3'd3) begin miscompares++; $display("FAIL bp_usage0_hold got %0d want 3", usage0); end
        if (valid0 !== 1'b1 || data0 !== 8'hA0) begin miscompares++; $display("FAIL bp_stable0 got %b/%h want 1/a0", valid0, data0); end
        if (valid1 !== 1'b1 || data1 !== 8'hA0) begin miscompares++; $display("FAIL bp_stable1 got %b/%h want 1/a0", valid1, data1); end
        for (int i = 0; i < 5; i++) begin
            step();
            rdy = 1'b1;
            #1;
            vectors += 2;
            if (valid0 !== ev0[i] || (ev0[i] && data0 !== ed0[i])) begin
                miscompares++; $display("FAIL bp_drain0 cyc %0d got %b/%h want %b/%h", i, valid0, data0, ev0[i], ed0[i]);
            end
            if (valid1 !== ev1[i] || (ev1[i] && data1 !== ed1[i])) begin
                miscompares++; $display("FAIL bp_drain1 cyc %0d got %b/%h want %b/%h", i, valid1, data1, ev1[i], ed1[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_seq [10] = '{8'hB0, 8'hB1, 8'hB2, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            up_if.valid = 1'b1;
            up_if.data  = 8'hB0 + 8'(i);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            rdy = 1'b1;
            up_if.valid = 1'b1;
            up_if.data  = 8'hC0 + 8'(i);
            #1;
            vectors += 4;
            if (ready0 !== 1'b1) begin miscompares++; $display("FAIL b2b_ready0 cyc %0d got %b want 1", i, ready0); end
            if (valid0 !== 1'b1) begin miscompares++; $display("FAIL b2b_valid0 cyc %0d got %b want 1", i, valid0); end
            if (usage0 !== 3'd3) begin miscompares++; $display("FAIL b2b_usage0 cyc %0d got %0d want 3", i, usage0); end
            if (data0 !== exp_seq[i]) begin miscompares++; $display("FAIL b2b_data0 cyc %0d got %h want %h", i, data0, exp_seq[i]); end
        end
        drain();
        vectors += 2;
        if (usage0 !== 3'd0) begin miscompares++; $display("FAIL b2b_empty0 got %0d want 0", usage0); end
        if (usage1 !== 3'd0) begin miscompares++; $display("FAIL b2b_empty1 got %0d want 0", usage1); end
    endtask

    task automatic test_bubble();
        logic       ev [3] = '{1'b1, 1'b1, 1'b0};
        logic [7:0] ed [3] = '{8'h55, 8'h66, 8'h00};
        rdy = 1'b0;
        step(); up_if.valid = 1'b1; up_if.data = 8'h55;
        step(); up_if.valid = 1'b0;
        step(); up_if.valid = 1'b1; up_if.data = 8'h66;
        step(); up_if.valid = 1'b0;
        step();
        #1;
        vectors += 3;
        if (usage0 !== 3'd2) begin miscompares++; $display("FAIL bubble_usage0 got %0d want 2", usage0); end
        if (ready0 !== 1'b1) begin miscompares++; $display("FAIL bubble_ready0 got %b want 1", ready0); end
        if (valid0 !== 1'b1 || data0 !== 8'h55) begin miscompares++; $display("FAIL bubble_head0 got %b/%h want 1/55", valid0, data0); end
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            #1;
            vectors += 1;
            if (valid0 !== ev[i] || (ev[i] && data0 !== ed[i])) begin
                miscompares++; $display("FAIL bubble_out0 cyc %0d got %b/%h want %b/%h", i, valid0, data0, ev[i], ed[i]);
            end
        end
    endtask

    task automatic test_clear();
        rdy = 1'b0;
        step(); up_if.valid = 1'b1; up_if.data = 8'hD1;
        step(); up_if.data = 8'hD2;
        step(); up_if.valid = 1'b0;
        step();
        clr = 1'b1; rdy = 1'b1; up_if.valid = 1'b1; up_if.data = 8'hD3;
        #1;
        vectors += 5;
        if (usage0 !== 3'd2) begin miscompares++; $display("FAIL clr_usage0_before got %0d want 2", usage0); end
        if (valid0 !== 1'b0) begin miscompares++; $display("FAIL clr_valid0 got %b want 0", valid0); end
        if (ready0 !== 1'b0) begin miscompares++; $display("FAIL clr_ready0 got %b want 0", ready0); end
        if (valid1 !== 1'b0) begin miscompares++; $display("FAIL clr_valid1 got %b want 0", valid1); end
        if (ready1 !== 1'b0) begin miscompares++; $display("FAIL clr_ready1 got %b want 0", ready1); end
        step();
        clr = 1'b0; up_if.valid = 1'b0;
        #1;
        vectors += 2;
        if (usage0 !== 3'd0) begin miscompares++; $display("FAIL clr_usage0_after got %0d want 0", usage0); end
        if (usage1 !== 3'd0) begin miscompares++; $display("FAIL clr_usage1_after got %0d want 0", usage1); end
        for (int i = 0; i < 4; i++) begin
            step();
            #1;
            vectors += 2;
            if (valid0 !== 1'b0) begin miscompares++; $display("FAIL clr_stale0 cyc %0d got %b want 0", i, valid0); end
            if (valid1 !== 1'b0) begin miscompares++; $display("FAIL clr_stale1 cyc %0d got %b want 0", i, valid1); end
        end
    endtask

    task automatic test_reset_mid();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            up_if.valid = 1'b1;
            up_if.data  = 8'hE0 + 8'(i);
        end
        step();
        up_if.valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        vectors += 5;
        if (valid0 !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid0 got %b want 0", valid0); end
        if (data0 !== 8'h00) begin miscompares++; $display("FAIL rstmid_data0 got %h want 00", data0); end
        if (usage0 !== 3'd0) begin miscompares++; $display("FAIL rstmid_usage0 got %0d want 0", usage0); end
        if (ready0 !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready0 got %b want 1", ready0); end
        if (usage1 !== 3'd0) begin miscompares++; $display("FAIL rstmid_usage1 got %0d want 0", usage1); end
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            #1;
            vectors += 2;
            if (valid0 !== 1'b0) begin miscompares++; $display("FAIL rstmid_stale0 cyc %0d got %b want 0", i, valid0); end
            if (valid1 !== 1'b0) begin miscompares++; $display("FAIL rstmid_stale1 cyc %0d got %b want 0", i, valid1); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_backpressure();
        test_back_to_back();
        test_bubble();
        test_clear();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
